// File: rtl/traffic_pkg.sv
// Light encoding and FSM state type shared by the intersection controller.
// WALK_A/WALK_B exist only in builds that define PED_WALK_EN.
package traffic_pkg;

    typedef logic [1:0] light_t;

    localparam light_t RED    = 2'd0;
    localparam light_t GREEN  = 2'd1;
    localparam light_t YELLOW = 2'd2;

    typedef enum logic [2:0] {
        NS_GREEN,
        NS_YELLOW,
        ALLRED_A,
        EW_GREEN,
        EW_YELLOW,
        ALLRED_B
`ifdef PED_WALK_EN
        ,
        WALK_A,
        WALK_B
`endif
    } state_t;

endpackage

// File: rtl/intersection_controller_phase_timer.sv
// Phase duration down-counter: loads DUR-1 on state entry, counts to zero and holds there.
// The expired flag is the terminal-count compare used by the FSM to advance.
module phase_timer #(
    parameter int TMR_W   = 8,
    parameter int RST_VAL = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [TMR_W-1:0] load_val,
    output logic             expired
);

    logic [TMR_W-1:0] count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= TMR_W'(RST_VAL);
        end else if (load) begin
            count <= load_val;
        end else if (count != '0) begin
            count <= count - 1'b1;
        end
    end

    assign expired = (count == '0);

endmodule

// File: rtl/intersection_controller.sv
// Two-way intersection sequencer: NS rests in green, EW is served on request, with all-red
// clearance between greens. Define PED_WALK_EN to add pedestrian walk phases after clearance.
//
// state     | meaning
// ----------+---------------------------------------------------------------
// NS_GREEN  | main road green; re-arms every GREEN_CYC until EW demand seen
// NS_YELLOW | main road yellow
// ALLRED_A  | clearance before EW green (or WALK_A)
// EW_GREEN  | side road green, fixed GREEN_CYC
// EW_YELLOW | side road yellow
// ALLRED_B  | clearance before NS green (or WALK_B); reset state
// WALK_A    | pedestrian walk, then EW_GREEN (PED_WALK_EN only)
// WALK_B    | pedestrian walk, then NS_GREEN (PED_WALK_EN only)
module intersection_controller
    import traffic_pkg::*;
#(
    parameter int GREEN_CYC  = 8,
    parameter int YELLOW_CYC = 3,
    parameter int ALLRED_CYC = 2,
    parameter int WALK_CYC   = 4,
    parameter int TMR_W      = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ew_req,
    input  logic       ped_req,
    output logic [1:0] ns_light,
    output logic [1:0] ew_light,
    output logic       ped_walk
);

    localparam int TMR_MAX = (1 << TMR_W) - 1;

    if (GREEN_CYC < 1 || GREEN_CYC > TMR_MAX ||
        YELLOW_CYC < 1 || YELLOW_CYC > TMR_MAX ||
        ALLRED_CYC < 1 || ALLRED_CYC > TMR_MAX ||
        WALK_CYC < 1 || WALK_CYC > TMR_MAX) begin : g_bad_cfg
        $error("intersection_controller: every *_CYC must lie in 1..2**TMR_W-1");
    end

    state_t           state;
    state_t           state_nxt;
    logic             expired;
    logic [TMR_W-1:0] load_val;
    logic             ew_pend;
    logic             ew_clr;
    logic             ped_go;

    function automatic logic [TMR_W-1:0] dur_m1(input state_t s);
        case (s)
            NS_GREEN, EW_GREEN:   dur_m1 = TMR_W'(GREEN_CYC - 1);
            NS_YELLOW, EW_YELLOW: dur_m1 = TMR_W'(YELLOW_CYC - 1);
`ifdef PED_WALK_EN
            WALK_A, WALK_B:       dur_m1 = TMR_W'(WALK_CYC - 1);
`endif
            default:              dur_m1 = TMR_W'(ALLRED_CYC - 1);
        endcase
    endfunction

    phase_timer #(
        .TMR_W   (TMR_W),
        .RST_VAL (ALLRED_CYC - 1)
    ) u_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (expired),
        .load_val (load_val),
        .expired  (expired)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ALLRED_B;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        if (expired) begin
            case (state)
                NS_GREEN:  if (ew_pend || ew_req) state_nxt = NS_YELLOW;
                NS_YELLOW: state_nxt = ALLRED_A;
`ifdef PED_WALK_EN
                ALLRED_A:  state_nxt = ped_go ? WALK_A : EW_GREEN;
                ALLRED_B:  state_nxt = ped_go ? WALK_B : NS_GREEN;
                WALK_A:    state_nxt = EW_GREEN;
                WALK_B:    state_nxt = NS_GREEN;
`else
                ALLRED_A:  state_nxt = EW_GREEN;
                ALLRED_B:  state_nxt = NS_GREEN;
`endif
                EW_GREEN:  state_nxt = EW_YELLOW;
                EW_YELLOW: state_nxt = ALLRED_B;
                default:   state_nxt = ALLRED_B;
            endcase
        end
    end

    // Every expiry reloads, including NS_GREEN re-arming itself while idle.
    assign load_val = dur_m1(state_nxt);

    // A request on the very edge EW_GREEN is entered is kept, so it is never lost.
    assign ew_clr = expired && (state_nxt == EW_GREEN);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ew_pend <= 1'b0;
        end else begin
            ew_pend <= ew_req | (ew_pend & ~ew_clr);
        end
    end

`ifdef PED_WALK_EN
    logic ped_pend;
    logic in_walk;
    logic walk_entry;

    assign in_walk    = (state == WALK_A) || (state == WALK_B);
    assign walk_entry = expired && ((state_nxt == WALK_A) || (state_nxt == WALK_B));
    assign ped_go     = ped_pend;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ped_pend <= 1'b0;
        end else begin
            ped_pend <= (ped_req & ~in_walk) | (ped_pend & ~walk_entry);
        end
    end
`else
    logic unused_ped;
    assign unused_ped = ped_req;
    assign ped_go     = 1'b0;
`endif

    always_comb begin
        ns_light = RED;
        ew_light = RED;
        ped_walk = 1'b0;
        case (state)
            NS_GREEN:  ns_light = GREEN;
            NS_YELLOW: ns_light = YELLOW;
            EW_GREEN:  ew_light = GREEN;
            EW_YELLOW: ew_light = YELLOW;
`ifdef PED_WALK_EN
            WALK_A, WALK_B: ped_walk = 1'b1;
`endif
            default: ;
        endcase
    end

`ifndef SYNTHESIS
    a_no_conflict: assert property (@(posedge clk) disable iff (rst)
        ((ns_light == RED) || (ew_light == RED)) && (!ped_walk || (ns_light == RED && ew_light == RED)));
`endif

endmodule

// File: tb/tb_intersection_controller.sv
// Directed bench for intersection_controller: reset, NS rest, EW service, held and
// last-cycle requests, mid-phase reset and the optional pedestrian walk.
module tb_intersection_controller;
    import traffic_pkg::*;

    localparam logic [1:0] R = 2'd0;
    localparam logic [1:0] G = 2'd1;
    localparam logic [1:0] Y = 2'd2;

    logic       clk;
    logic       rst;
    logic       ew_req;
    logic       ped_req;
    logic [1:0] ns_light;
    logic [1:0] ew_light;
    logic       ped_walk;

    int total = 0;
    int bad   = 0;

    intersection_controller dut (
        .clk      (clk),
        .rst      (rst),
        .ew_req   (ew_req),
        .ped_req  (ped_req),
        .ns_light (ns_light),
        .ew_light (ew_light),
        .ped_walk (ped_walk)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish, want finish before 200000");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [1:0] ns, input logic [1:0] ew, input logic w);
        total++;
        assert ({ns_light, ew_light, ped_walk} === {ns, ew, w}) else begin
            bad++;
            $error("FAIL %s: got ns=%0d ew=%0d walk=%0d, want ns=%0d ew=%0d walk=%0d",
                   tag, ns_light, ew_light, ped_walk, ns, ew, w);
        end
    endtask

    task automatic hold(input string tag, input logic [1:0] ns, input logic [1:0] ew,
                        input logic w, input int n);
        for (int i = 0; i < n; i++) begin
            chk(tag, ns, ew, w);
            @(negedge clk);
        end
    endtask

    // From the current NS green cycle: ns_cycles more NS green, then the full EW service.
    task automatic serve_ew(input string tag, input int ns_cycles);
        hold({tag, "_nsg"}, G, R, 1'b0, ns_cycles);
        hold({tag, "_nsy"}, Y, R, 1'b0, 3);
        hold({tag, "_ara"}, R, R, 1'b0, 2);
        hold({tag, "_ewg"}, R, G, 1'b0, 8);
        hold({tag, "_ewy"}, R, Y, 1'b0, 3);
        hold({tag, "_arb"}, R, R, 1'b0, 2);
    endtask

    initial begin
        rst     = 1'b1;
        ew_req  = 1'b0;
        ped_req = 1'b0;
        repeat (2) @(negedge clk);
        chk("reset", R, R, 1'b0);

        // 1: release, two all-red cycles, then indefinite NS rest
        rst = 1'b0;
        hold("t1_allred", R, R, 1'b0, 2);
        hold("t1_rest", G, R, 1'b0, 40);

        // 2: one-cycle pulse in NS green cycle 3 of a period
        hold("t2_pre", G, R, 1'b0, 2);
        ew_req = 1'b1;
        hold("t2_req", G, R, 1'b0, 1);
        ew_req = 1'b0;
        serve_ew("t2", 5);

        // 4: request only on the expiry cycle still counts
        hold("t4_pre", G, R, 1'b0, 7);
        ew_req = 1'b1;
        hold("t4_req", G, R, 1'b0, 1);
        ew_req = 1'b0;
        serve_ew("t4", 0);

        // 3: held request gives a 26-cycle period; re-set during EW green gives one more
        ew_req = 1'b1;
        serve_ew("t3a", 8);
        serve_ew("t3b", 8);
        ew_req = 1'b0;
        serve_ew("t3c", 8);
        hold("t3_rest", G, R, 1'b0, 20);

        // 5: reset in EW green cycle 5 forces all-red in the same cycle
        ew_req = 1'b1;
        hold("t5_req", G, R, 1'b0, 1);
        ew_req = 1'b0;
        hold("t5_nsg", G, R, 1'b0, 3);
        hold("t5_nsy", Y, R, 1'b0, 3);
        hold("t5_ara", R, R, 1'b0, 2);
        hold("t5_ewg", R, G, 1'b0, 4);
        chk("t5_ewg5", R, G, 1'b0);
        #2 rst = 1'b1;
        #1 chk("t5_async", R, R, 1'b0);
        @(negedge clk);
        chk("t5_inrst", R, R, 1'b0);
        rst = 1'b0;
        hold("t5_allred", R, R, 1'b0, 2);
        hold("t5_nsg_after", G, R, 1'b0, 1);

        // 6: pedestrian request during EW green
        hold("t6_pre", G, R, 1'b0, 7);
        ew_req = 1'b1;
        hold("t6_req", G, R, 1'b0, 1);
        ew_req = 1'b0;
        hold("t6_nsg", G, R, 1'b0, 7);
        hold("t6_nsy", Y, R, 1'b0, 3);
        hold("t6_ara", R, R, 1'b0, 2);
        hold("t6_ewg", R, G, 1'b0, 2);
        ped_req = 1'b1;
        hold("t6_ped", R, G, 1'b0, 1);
        ped_req = 1'b0;
        hold("t6_ewg2", R, G, 1'b0, 5);
        hold("t6_ewy", R, Y, 1'b0, 3);
        hold("t6_arb", R, R, 1'b0, 2);
`ifdef PED_WALK_EN
        hold("t6_walk", R, R, 1'b1, 4);
`endif
        hold("t6_rest", G, R, 1'b0, 10);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
